usb_utm_rx_ctrl: RTL and testbench
==================================

# usb_utm_rx_ctrl

Receive-path sequencer for the FS-only UTM. Consumes the per-bit stream produced by the UTM data-recovery, NRZI-decode and unstuff stages, and turns it into UTMI receive signalling. It hunts for SYNC, assembles unstuffed bits LSB-first into bytes, detects EOP and stuff errors, and generates rx_active, rx_valid, rx_error and rx_data. It sits between the UTM bit pipeline and the UTMI receive interface, and is blanked while the transmitter owns the bus.

## Interface
- SYNC_MIN_ZEROS, 5: minimum decoded 0 bits before the terminating 1 for a SYNC to be accepted (hubs may drop leading bits); range 1..7.
- SYNC_TIMEOUT, 16: bit strobes allowed in SYNC hunt before abandoning; range 8..31.
- clk  in  1  clock, 48 MHz; one bit time = 4 clocks.
- rst  in  1  reset; one clock; asynchronous and active-high.
- line_state  in  2  utmi_line_state_t, already synchronized and settled (SE0=00, J=01, K=10, SE1=11).
- bit_strobe  in  1  one-clock pulse at mid-bit; all other bit inputs are qualified by it.
- bit_val  in  1  NRZI-decoded bit value at this strobe.
- bit_stuff  in  1  this bit is a stuff bit; discard it.
- stuff_err  in  1  seven consecutive 1s seen (bit stuff violation).
- tx_active  in  1  transmitter owns the bus; receiver is forced idle.
- rx_active  out  1  packet in progress (post-SYNC until EOP/error); reset 0.
- rx_valid  out  1  one-clock pulse, rx_data holds a new byte; reset 0.
- rx_data  out  8  received byte, LSB first on wire; reset 8'h00.
- rx_error  out  1  one-clock pulse, packet aborted; reset 0.

## Operation
- State machine (usb_rx_state_t): IDLE, SYNC, DATA, EOP, ERR_WAIT. Transitions are evaluated only on bit_strobe, except tx_active.
- tx_active high, in any state: next clock is IDLE. All counters clear, rx_active = 0, and no rx_valid or rx_error is generated.
- IDLE → SYNC: strobe with line_state == K. The zero counter clears and the bit counter clears.
- SYNC:
  - bit_val=0 increments zero_cnt, saturating at 7.
  - bit_val=1 with zero_cnt ≥ SYNC_MIN_ZEROS → DATA, rx_active set.
  - bit_val=1 with zero_cnt below the minimum → IDLE.
  - line_state SE0, or strobe count reaching SYNC_TIMEOUT → IDLE, silently with no rx_error.
- DATA, per strobe, in priority order:
  - line_state == SE0 → EOP.
  - stuff_err → ERR_WAIT, rx_error pulse.
  - bit_stuff → ignore the bit.
  - Otherwise shift bit_val into the MSB of a shift register that shifts right, and increment the 3-bit bit_cnt.
  - When bit_cnt wraps 7→0: rx_data ← the completed byte, rx_valid pulses.
- EOP:
  - Entering EOP with bit_cnt ≠ 0 flags a pending error.
  - Strobe with line_state == J → IDLE.
  - At that exit, rx_error pulses if the error is pending; rx_active clears.
  - SE0 may persist any number of strobes (bus reset is handled elsewhere).
  - K or SE1 during EOP → ERR_WAIT with an rx_error pulse.
- ERR_WAIT: rx_active clears. Leave to IDLE after 8 consecutive strobes with line_state == J.
- rx_error is never asserted while rx_active is low.

## Timing
- rx_active rises one clock after the strobe that carries the SYNC-terminating 1.
- rx_valid is registered: high for exactly one clock, one clock after the strobe carrying the 8th data bit. rx_data is updated in the same clock and held until the next rx_valid.
- rx_error, when it occurs:
  - It is high for one clock, one clock after the causing strobe, with rx_active still high.
  - rx_active falls on the following clock.
- Normal EOP end: rx_active falls one clock after the J strobe.
- Minimum byte spacing on rx_valid is 32 clocks, or 36 clocks across a stuff bit.
- Asynchronous rst mid-packet: all outputs go to their reset values immediately, the state goes to IDLE, and no rx_error is generated.
- tx_active asserted mid-packet: rx_active drops on the next clock with no rx_valid or rx_error. After tx_active falls, reception resumes only via a new IDLE→SYNC.

## Structure
- Add the following to usb_utmi_pkg:
  - usb_rx_state_t enum.
  - Constants USB_SYNC_MIN_ZEROS and USB_SYNC_TIMEOUT, used as defaults.
  - USB_RX_IDLE_J_BITS = 8.
- utmi_line_state_t is reused from usb_utmi_pkg.
- Single module. Byte assembly (shift register + bit_cnt + rx_valid) may be split into usb_rx_byte_asm if the file exceeds ~300 lines; the FSM stays in usb_utm_rx_ctrl.

## Test plan
- Full SYNC (7 zeros, 1), bytes 8'hA5 then 8'h3C, SE0 ×2 then J:
  - Two rx_valid pulses with rx_data A5 and 3C, 32 clocks apart.
  - rx_active falls one clock after the J strobe; no rx_error.
- Short SYNC, 3 zeros then 1 (SYNC_MIN_ZEROS=5): rx_active stays 0 and the FSM returns to IDLE.
- Byte 8'hFF with a stuff bit after six 1s: one rx_valid with rx_data FF, and the stuff bit is not counted.
- stuff_err on the 4th bit of the second byte:
  - One rx_error pulse, then rx_active low the next clock.
  - No second rx_valid; return to IDLE after 8 J strobes.
- EOP after 12 data bits: one rx_valid for byte 1, then rx_error at the J strobe and rx_active low.
- Two cases during byte 2, each with no rx_valid/rx_error afterwards and clean reception of a following packet:
  - tx_active pulse: rx_active low the next clock.
  - rst asserted: rx_active low the same cycle.

Source files
------------

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types and constants for the FS-only UTM.
package usb_utmi_pkg;

    typedef enum logic [1:0] {
        LsSe0 = 2'b00,
        LsJ   = 2'b01,
        LsK   = 2'b10,
        LsSe1 = 2'b11
    } utmi_line_state_t;

    typedef enum logic [2:0] {
        RxIdle,
        RxSync,
        RxData,
        RxEop,
        RxErrWait
    } usb_rx_state_t;

    localparam int unsigned USB_SYNC_MIN_ZEROS = 5;
    localparam int unsigned USB_SYNC_TIMEOUT   = 16;
    localparam int unsigned USB_RX_IDLE_J_BITS = 8;

endpackage

// File: rtl/usb_utm_rx_ctrl.sv
// Receive sequencer: SYNC hunt, LSB-first byte assembly, EOP and stuff-error handling,
// producing UTMI rx_active / rx_valid / rx_data / rx_error.
module usb_utm_rx_ctrl
    import usb_utmi_pkg::*;
#(
    parameter int unsigned SYNC_MIN_ZEROS = USB_SYNC_MIN_ZEROS,
    parameter int unsigned SYNC_TIMEOUT   = USB_SYNC_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  utmi_line_state_t line_state,
    input  logic             bit_strobe,
    input  logic             bit_val,
    input  logic             bit_stuff,
    input  logic             stuff_err,
    input  logic             tx_active,
    output logic             rx_active,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             rx_error
);

    localparam logic [2:0] MinZeros = 3'(SYNC_MIN_ZEROS);
    localparam logic [4:0] Timeout  = 5'(SYNC_TIMEOUT);
    localparam logic [2:0] JLast    = 3'(USB_RX_IDLE_J_BITS - 1);

    usb_rx_state_t state_q;
    logic [2:0]    zero_cnt_q;
    logic [4:0]    sync_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [2:0]    j_cnt_q;
    logic [6:0]    shift_q;
    logic          err_pend_q;
    logic [4:0]    sync_cnt_inc;

    assign sync_cnt_inc = sync_cnt_q + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RxIdle;
            zero_cnt_q <= 3'd0;
            sync_cnt_q <= 5'd0;
            bit_cnt_q  <= 3'd0;
            j_cnt_q    <= 3'd0;
            shift_q    <= 7'd0;
            err_pend_q <= 1'b0;
            rx_active  <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            rx_error   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            if (tx_active) begin
                state_q    <= RxIdle;
                zero_cnt_q <= 3'd0;
                sync_cnt_q <= 5'd0;
                bit_cnt_q  <= 3'd0;
                j_cnt_q    <= 3'd0;
                err_pend_q <= 1'b0;
                rx_active  <= 1'b0;
            end else begin
                unique case (state_q)
                    RxIdle: begin
                        // Also retires rx_active one clock after an errored EOP exit.
                        rx_active <= 1'b0;
                        if (bit_strobe && line_state == LsK) begin
                            state_q    <= RxSync;
                            zero_cnt_q <= 3'd0;
                            sync_cnt_q <= 5'd0;
                            bit_cnt_q  <= 3'd0;
                        end
                    end
                    RxSync: begin
                        rx_active <= 1'b0;
                        if (bit_strobe) begin
                            sync_cnt_q <= sync_cnt_inc;
                            if (line_state == LsSe0) begin
                                state_q <= RxIdle;
                            end else if (bit_val) begin
                                if (zero_cnt_q >= MinZeros) begin
                                    state_q   <= RxData;
                                    rx_active <= 1'b1;
                                    bit_cnt_q <= 3'd0;
                                end else begin
                                    state_q <= RxIdle;
                                end
                            end else if (sync_cnt_inc >= Timeout) begin
                                state_q <= RxIdle;
                            end else if (zero_cnt_q != 3'd7) begin
                                zero_cnt_q <= zero_cnt_q + 3'd1;
                            end
                        end
                    end
                    RxData: begin
                        if (bit_strobe) begin
                            if (line_state == LsSe0) begin
                                state_q    <= RxEop;
                                err_pend_q <= (bit_cnt_q != 3'd0);
                            end else if (stuff_err) begin
                                state_q  <= RxErrWait;
                                rx_error <= 1'b1;
                                j_cnt_q  <= 3'd0;
                            end else if (!bit_stuff) begin
                                shift_q   <= {bit_val, shift_q[6:1]};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    rx_data  <= {bit_val, shift_q};
                                    rx_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    RxEop: begin
                        if (bit_strobe) begin
                            if (line_state == LsJ) begin
                                state_q <= RxIdle;
                                // With an error pending, rx_active stays up for the error pulse.
                                if (err_pend_q) begin
                                    rx_error <= 1'b1;
                                end else begin
                                    rx_active <= 1'b0;
                                end
                            end else if (line_state != LsSe0) begin
                                state_q  <= RxErrWait;
                                rx_error <= 1'b1;
                                j_cnt_q  <= 3'd0;
                            end
                        end
                    end
                    RxErrWait: begin
                        rx_active <= 1'b0;
                        if (bit_strobe) begin
                            if (line_state != LsJ) begin
                                j_cnt_q <= 3'd0;
                            end else if (j_cnt_q == JLast) begin
                                state_q <= RxIdle;
                            end else begin
                                j_cnt_q <= j_cnt_q + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state_q   <= RxIdle;
                        rx_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_utm_rx_ctrl.sv
// Self-checking bench for usb_utm_rx_ctrl: packets are built as strobe lists and the
// expected bytes, times and error pulses are derived from how each packet was built.
module tb_usb_utm_rx_ctrl;
    import usb_utmi_pkg::*;

    localparam int MinZeros = 5;

    typedef struct packed {
        utmi_line_state_t ls;
        logic             val;
        logic             stuff;
        logic             serr;
    } beat_t;

    logic             clk        = 1'b0;
    logic             rst        = 1'b0;
    utmi_line_state_t line_state = LsJ;
    logic             bit_strobe = 1'b0;
    logic             bit_val    = 1'b0;
    logic             bit_stuff  = 1'b0;
    logic             stuff_err  = 1'b0;
    logic             tx_active  = 1'b0;
    logic             rx_active;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_error;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    int ones_run = 0;

    beat_t      beats[$];
    int         strobe_cyc[0:2047];
    logic [7:0] exp_data[$];
    int         exp_idx[$];
    logic [7:0] got_data[$];
    int         got_cyc[$];
    int         err_cyc[$];
    logic       err_act[$];
    int         rise_cyc[$];
    int         fall_cyc[$];
    logic       act_prev = 1'b0;

    usb_utm_rx_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .line_state (line_state),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val),
        .bit_stuff  (bit_stuff),
        .stuff_err  (stuff_err),
        .tx_active  (tx_active),
        .rx_active  (rx_active),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_error   (rx_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_data.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        if (rx_error) begin
            err_cyc.push_back(cyc);
            err_act.push_back(rx_active);
        end
        if (rx_active && !act_prev) rise_cyc.push_back(cyc);
        if (!rx_active && act_prev) fall_cyc.push_back(cyc);
        act_prev <= rx_active;
    end

    task automatic clear_run();
        @(posedge clk);
        beats.delete();
        exp_data.delete();
        exp_idx.delete();
        got_data.delete();
        got_cyc.delete();
        err_cyc.delete();
        err_act.delete();
        rise_cyc.delete();
        fall_cyc.delete();
    endtask

    function automatic void add(utmi_line_state_t ls, logic v, logic st, logic se);
        beat_t b;
        b.ls    = ls;
        b.val   = v;
        b.stuff = st;
        b.serr  = se;
        beats.push_back(b);
    endfunction

    // K entry strobe, nz counted zeros, then the terminating 1; returns that 1's index.
    function automatic int add_sync(int nz);
        add(LsK, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nz; i++) add(LsJ, 1'b0, 1'b0, 1'b0);
        add(LsJ, 1'b1, 1'b0, 1'b0);
        ones_run = 0;
        return beats.size() - 1;
    endfunction

    // First nbits of b, LSB first, with a stuff bit after every six consecutive 1s.
    function automatic void add_byte(logic [7:0] b, int nbits, logic expect_it);
        for (int i = 0; i < nbits; i++) begin
            add(LsJ, b[i], 1'b0, 1'b0);
            if (i == 7 && expect_it) begin
                exp_data.push_back(b);
                exp_idx.push_back(beats.size() - 1);
            end
            ones_run = b[i] ? ones_run + 1 : 0;
            if (ones_run == 6) begin
                add(LsJ, 1'b0, 1'b1, 1'b0);
                ones_run = 0;
            end
        end
    endfunction

    function automatic int add_eop();
        add(LsSe0, 1'b0, 1'b0, 1'b0);
        add(LsSe0, 1'b0, 1'b0, 1'b0);
        add(LsJ, 1'b1, 1'b0, 1'b0);
        return beats.size() - 1;
    endfunction

    function automatic void add_idle(int n);
        for (int i = 0; i < n; i++) add(LsJ, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic play(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            strobe_cyc[i] = cyc;
            line_state = beats[i].ls;
            bit_val    = beats[i].val;
            bit_stuff  = beats[i].stuff;
            stuff_err  = beats[i].serr;
            bit_strobe = 1'b1;
            @(negedge clk);
            bit_strobe = 1'b0;
            bit_val    = 1'b0;
            bit_stuff  = 1'b0;
            stuff_err  = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic play_all();
        play(0, beats.size() - 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (rx_active !== 1'b0) begin
            n_errors++; $display("FAIL reset_rx_active: got %b want 0", rx_active);
        end
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid);
        end
        n_checks++;
        if (rx_error !== 1'b0) begin
            n_errors++; $display("FAIL reset_rx_error: got %b want 0", rx_error);
        end
        n_checks++;
        if (rx_data !== 8'h00) begin
            n_errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_sync();
        int s1;
        int jx;
        clear_run();
        s1 = add_sync(6);
        add_byte(8'hA5, 8, 1'b1);
        add_byte(8'h3C, 8, 1'b1);
        jx = add_eop();
        add_idle(2);
        play_all();
        n_checks++;
        if (got_data.size() != 2) begin
            n_errors++; $display("FAIL full_count: got %0d bytes want 2", got_data.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got_data[k] !== exp_data[k]) begin
                    n_errors++; $display("FAIL full_data%0d: got %h want %h", k, got_data[k], exp_data[k]);
                end
                n_checks++;
                if (got_cyc[k] != strobe_cyc[exp_idx[k]] + 1) begin
                    n_errors++;
                    $display("FAIL full_valid_time%0d: got %0d want %0d", k, got_cyc[k],
                             strobe_cyc[exp_idx[k]] + 1);
                end
            end
            n_checks++;
            if (got_cyc[1] - got_cyc[0] != 32) begin
                n_errors++; $display("FAIL full_spacing: got %0d want 32", got_cyc[1] - got_cyc[0]);
            end
        end
        n_checks++;
        if (rise_cyc.size() != 1 || rise_cyc[0] != strobe_cyc[s1] + 1) begin
            n_errors++;
            $display("FAIL full_active_rise: got %0d rises first at %0d want 1 at %0d",
                     rise_cyc.size(), (rise_cyc.size() > 0) ? rise_cyc[0] : -1, strobe_cyc[s1] + 1);
        end
        n_checks++;
        if (fall_cyc.size() != 1 || fall_cyc[0] != strobe_cyc[jx] + 1) begin
            n_errors++;
            $display("FAIL full_active_fall: got %0d falls first at %0d want 1 at %0d",
                     fall_cyc.size(), (fall_cyc.size() > 0) ? fall_cyc[0] : -1, strobe_cyc[jx] + 1);
        end
        n_checks++;
        if (err_cyc.size() != 0) begin
            n_errors++; $display("FAIL full_no_error: got %0d errors want 0", err_cyc.size());
        end
        n_checks++;
        if (rx_data !== 8'h3C) begin
            n_errors++; $display("FAIL full_data_hold: got %h want 3c", rx_data);
        end
    endtask

    // 3 and 4 counted zeros must be rejected, 5 accepted.
    task automatic test_short_sync();
        int jx;
        clear_run();
        void'(add_sync(3));
        add_byte(8'hA5, 8, 1'b0);
        jx = add_eop();
        add_idle(2);
        void'(add_sync(4));
        add_byte(8'hC3, 8, 1'b0);
        jx = add_eop();
        add_idle(2);
        void'(add_sync(5));
        add_byte(8'h5A, 8, 1'b1);
        jx = add_eop();
        add_idle(2);
        play_all();
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'h5A) begin
            n_errors++;
            $display("FAIL short_sync_bytes: got %0d bytes first %h want 1 byte 5a", got_data.size(),
                     (got_data.size() > 0) ? got_data[0] : 8'h00);
        end
        n_checks++;
        if (rise_cyc.size() != 1) begin
            n_errors++; $display("FAIL short_sync_active: got %0d rises want 1", rise_cyc.size());
        end
        n_checks++;
        if (err_cyc.size() != 0) begin
            n_errors++; $display("FAIL short_sync_error: got %0d errors want 0", err_cyc.size());
        end
    endtask

    task automatic test_stuff();
        int jx;
        clear_run();
        void'(add_sync(6));
        add_byte(8'hFF, 8, 1'b1);
        jx = add_eop();
        add_idle(2);
        play_all();
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'hFF) begin
            n_errors++;
            $display("FAIL stuff_byte: got %0d bytes first %h want 1 byte ff", got_data.size(),
                     (got_data.size() > 0) ? got_data[0] : 8'h00);
        end else begin
            n_checks++;
            if (got_cyc[0] != strobe_cyc[exp_idx[0]] + 1) begin
                n_errors++;
                $display("FAIL stuff_valid_time: got %0d want %0d", got_cyc[0],
                         strobe_cyc[exp_idx[0]] + 1);
            end
        end
        n_checks++;
        if (err_cyc.size() != 0) begin
            n_errors++; $display("FAIL stuff_no_error: got %0d errors want 0", err_cyc.size());
        end
    endtask

    task automatic test_stuff_err();
        int e1;
        int e2;
        int jx;
        clear_run();
        void'(add_sync(6));
        add_byte(8'h5A, 8, 1'b1);
        add_byte(8'h07, 3, 1'b0);
        add(LsJ, 1'b1, 1'b0, 1'b1);
        e1 = beats.size() - 1;
        add_idle(7);
        // Only 7 J strobes: the receiver is still waiting and this packet is lost.
        void'(add_sync(6));
        add_byte(8'hC3, 8, 1'b0);
        jx = add_eop();
        add_idle(2);
        void'(add_sync(6));
        add_byte(8'h07, 3, 1'b0);
        add(LsJ, 1'b1, 1'b0, 1'b1);
        e2 = beats.size() - 1;
        add_idle(8);
        void'(add_sync(6));
        add_byte(8'h96, 8, 1'b1);
        jx = add_eop();
        add_idle(2);
        play_all();
        n_checks++;
        if (got_data.size() != 2) begin
            n_errors++; $display("FAIL serr_count: got %0d bytes want 2", got_data.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got_data[k] !== exp_data[k]) begin
                    n_errors++; $display("FAIL serr_data%0d: got %h want %h", k, got_data[k], exp_data[k]);
                end
            end
        end
        n_checks++;
        if (err_cyc.size() != 2) begin
            n_errors++; $display("FAIL serr_err_count: got %0d want 2", err_cyc.size());
        end else begin
            n_checks++;
            if (err_cyc[0] != strobe_cyc[e1] + 1 || err_act[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL serr_err_time: got %0d active %b want %0d active 1", err_cyc[0],
                         err_act[0], strobe_cyc[e1] + 1);
            end
            n_checks++;
            if (err_cyc[1] != strobe_cyc[e2] + 1) begin
                n_errors++; $display("FAIL serr_err2_time: got %0d want %0d", err_cyc[1], strobe_cyc[e2] + 1);
            end
        end
        n_checks++;
        if (fall_cyc.size() < 1 || fall_cyc[0] != strobe_cyc[e1] + 2) begin
            n_errors++;
            $display("FAIL serr_active_fall: got %0d want %0d",
                     (fall_cyc.size() > 0) ? fall_cyc[0] : -1, strobe_cyc[e1] + 2);
        end
        n_checks++;
        if (rise_cyc.size() != 3) begin
            n_errors++; $display("FAIL serr_rises: got %0d want 3", rise_cyc.size());
        end
    endtask

    task automatic test_eop_early();
        int jx;
        clear_run();
        void'(add_sync(6));
        add_byte(8'h81, 8, 1'b1);
        add_byte(8'h0F, 4, 1'b0);
        jx = add_eop();
        add_idle(2);
        play_all();
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'h81) begin
            n_errors++;
            $display("FAIL eop_early_bytes: got %0d bytes first %h want 1 byte 81", got_data.size(),
                     (got_data.size() > 0) ? got_data[0] : 8'h00);
        end
        n_checks++;
        if (err_cyc.size() != 1 || err_cyc[0] != strobe_cyc[jx] + 1 || err_act[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL eop_early_error: got %0d errors first at %0d want 1 at %0d with rx_active",
                     err_cyc.size(), (err_cyc.size() > 0) ? err_cyc[0] : -1, strobe_cyc[jx] + 1);
        end
        n_checks++;
        if (fall_cyc.size() != 1 || fall_cyc[0] != strobe_cyc[jx] + 2) begin
            n_errors++;
            $display("FAIL eop_early_fall: got %0d falls first at %0d want 1 at %0d", fall_cyc.size(),
                     (fall_cyc.size() > 0) ? fall_cyc[0] : -1, strobe_cyc[jx] + 2);
        end
    endtask

    // 20 zeros exceed the hunt budget; 14 zeros stay inside it with a saturated zero count.
    task automatic test_timeout();
        int jx;
        clear_run();
        void'(add_sync(20));
        add_byte(8'h3C, 8, 1'b0);
        jx = add_eop();
        add_idle(2);
        void'(add_sync(14));
        add_byte(8'hE7, 8, 1'b1);
        jx = add_eop();
        add_idle(2);
        play_all();
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'hE7) begin
            n_errors++;
            $display("FAIL timeout_bytes: got %0d bytes first %h want 1 byte e7", got_data.size(),
                     (got_data.size() > 0) ? got_data[0] : 8'h00);
        end
        n_checks++;
        if (err_cyc.size() != 0 || rise_cyc.size() != 1) begin
            n_errors++;
            $display("FAIL timeout_flags: got %0d errors %0d rises want 0 and 1", err_cyc.size(),
                     rise_cyc.size());
        end
    endtask

    // Interrupt during byte 2 with tx_active (use_rst=0) or rst (use_rst=1).
    task automatic test_abort(input bit use_rst);
        int cut;
        int jx;
        clear_run();
        void'(add_sync(6));
        add_byte(8'h6E, 8, 1'b1);
        cut = beats.size() + 3;
        add_byte(8'hB1, 8, 1'b0);
        jx = add_eop();
        add_idle(2);
        void'(add_sync(6));
        add_byte(8'h42, 8, 1'b1);
        jx = add_eop();
        add_idle(2);
        play(0, cut);
        n_checks++;
        if (rx_active !== 1'b1) begin
            n_errors++; $display("FAIL abort%0d_active_before: got %b want 1", use_rst, rx_active);
        end
        if (use_rst) begin
            #2 rst = 1'b1;
            #1;
            n_checks++;
            if (rx_active !== 1'b0 || rx_data !== 8'h00) begin
                n_errors++;
                $display("FAIL abort_rst_immediate: got active %b data %h want 0 00", rx_active, rx_data);
            end
            @(negedge clk);
            rst = 1'b0;
        end else begin
            tx_active = 1'b1;
            @(negedge clk);
            n_checks++;
            if (rx_active !== 1'b0) begin
                n_errors++; $display("FAIL abort_tx_next_clock: got %b want 0", rx_active);
            end
            tx_active = 1'b0;
        end
        play(cut + 1, beats.size() - 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (got_data.size() != 2) begin
            n_errors++; $display("FAIL abort%0d_count: got %0d bytes want 2", use_rst, got_data.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got_data[k] !== exp_data[k]) begin
                    n_errors++;
                    $display("FAIL abort%0d_data%0d: got %h want %h", use_rst, k, got_data[k], exp_data[k]);
                end
            end
        end
        n_checks++;
        if (err_cyc.size() != 0) begin
            n_errors++; $display("FAIL abort%0d_no_error: got %0d errors want 0", use_rst, err_cyc.size());
        end
    endtask

    task automatic test_random();
        int         nz;
        int         nb;
        int         n_acc;
        logic [7:0] b;
        clear_run();
        n_acc = 0;
        for (int p = 0; p < 12; p++) begin
            nz = $urandom_range(0, 7);
            void'(add_sync(nz));
            if (nz >= MinZeros) n_acc++;
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                add_byte(b, 8, nz >= MinZeros);
            end
            void'(add_eop());
            add_idle($urandom_range(1, 4));
        end
        play_all();
        n_checks++;
        if (got_data.size() != exp_data.size()) begin
            n_errors++;
            $display("FAIL random_count: got %0d bytes want %0d", got_data.size(), exp_data.size());
        end else begin
            for (int k = 0; k < exp_data.size(); k++) begin
                n_checks++;
                if (got_data[k] !== exp_data[k] || got_cyc[k] != strobe_cyc[exp_idx[k]] + 1) begin
                    n_errors++;
                    $display("FAIL random_byte%0d: got %h at %0d want %h at %0d", k, got_data[k],
                             got_cyc[k], exp_data[k], strobe_cyc[exp_idx[k]] + 1);
                end
            end
        end
        n_checks++;
        if (err_cyc.size() != 0 || rise_cyc.size() != n_acc || rx_active !== 1'b0) begin
            n_errors++;
            $display("FAIL random_flags: got %0d errors %0d rises active %b want 0, %0d, 0",
                     err_cyc.size(), rise_cyc.size(), rx_active, n_acc);
        end
    endtask

    initial begin
        test_reset();
        test_full_sync();
        test_short_sync();
        test_stuff();
        test_stuff_err();
        test_eop_early();
        test_timeout();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
